// File: rtl/dsp_fir_pkg.sv
// Shared types, default sizing and default coefficient set for the time-multiplexed FIR core.
package dsp_fir_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned COEF_W   = 16;
  localparam int unsigned FRAC_W   = 15;
  localparam int unsigned TAPS     = 16;

  // Accumulator width: full product plus log2(taps) guard bits.
  function automatic int unsigned acc_w(input int unsigned dw, input int unsigned cw,
                                        input int unsigned taps);
    return dw + cw + $clog2(taps);
  endfunction

  localparam int unsigned ACC_W = acc_w(SAMPLE_W, COEF_W, TAPS);

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic signed [COEF_W-1:0]   coef_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // 16-tap moving average, 1/16 per tap in Q1.15.
  localparam logic [TAPS*COEF_W-1:0] DEFAULT_COEFS = {TAPS{COEF_W'(2048)}};

endpackage

// File: rtl/dsp_fir_round_sat.sv
// Accumulator to sample conversion: optional round-half-up (DSP_FIR_ROUND_EN), arithmetic
// shift by the coefficient fraction, then saturation to the sample range.
module dsp_fir_round_sat
  import dsp_fir_pkg::*;
#(
  parameter int unsigned ACC_WIDTH  = ACC_W,
  parameter int unsigned DATA_WIDTH = SAMPLE_W,
  parameter int unsigned COEF_FRAC  = FRAC_W
) (
  input  logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [DATA_WIDTH-1:0] result_c
);

  // One spare bit so the rounding offset can never wrap the accumulator.
  localparam int unsigned EXT_W = ACC_WIDTH + 1;
  localparam logic signed [EXT_W-1:0] MAX_VAL =
    {{(EXT_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [EXT_W-1:0] MIN_VAL =
    {{(EXT_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
`ifdef DSP_FIR_ROUND_EN
  localparam logic signed [EXT_W-1:0] HALF = EXT_W'(1) << (COEF_FRAC-1);
`endif

  logic signed [EXT_W-1:0] biased_c;
  logic signed [EXT_W-1:0] shifted_c;

  always_comb begin
`ifdef DSP_FIR_ROUND_EN
    biased_c = EXT_W'(acc) + HALF;
`else
    biased_c = EXT_W'(acc);
`endif
    shifted_c = biased_c >>> COEF_FRAC;
    if (shifted_c > MAX_VAL) begin
      result_c = DATA_WIDTH'(MAX_VAL);
    end else if (shifted_c < MIN_VAL) begin
      result_c = DATA_WIDTH'(MIN_VAL);
    end else begin
      result_c = DATA_WIDTH'(shifted_c);
    end
  end

endmodule

// File: rtl/dsp_fir_core.sv
// Single-MAC FIR filter: one accepted sample is convolved over NUM_TAPS cycles through a shared
// multiplier. Output rounding is selected by DSP_FIR_ROUND_EN inside dsp_fir_round_sat.
module dsp_fir_core
  import dsp_fir_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = SAMPLE_W,
  parameter int unsigned COEF_WIDTH = COEF_W,
  parameter int unsigned COEF_FRAC  = FRAC_W,
  parameter int unsigned NUM_TAPS   = TAPS,
  parameter logic [NUM_TAPS*COEF_WIDTH-1:0] COEFS = DEFAULT_COEFS
) (
  input  logic                         clk_i,
  input  logic                         srst_i,
  input  logic                         sample_valid_i,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         data_valid_o
);

  localparam int unsigned ACC_WIDTH = acc_w(DATA_WIDTH, COEF_WIDTH, NUM_TAPS);
  localparam int unsigned PROD_W    = DATA_WIDTH + COEF_WIDTH;
  localparam int unsigned CNT_W     = $clog2(NUM_TAPS);
  localparam logic [CNT_W-1:0] LAST_TAP = CNT_W'(NUM_TAPS-1);

  state_t                         state;
  state_t                         state_next;
  logic signed [DATA_WIDTH-1:0]   delay [NUM_TAPS];
  logic        [CNT_W-1:0]        tap;
  logic signed [ACC_WIDTH-1:0]    acc;
  logic signed [DATA_WIDTH-1:0]   x_sel_c;
  logic signed [COEF_WIDTH-1:0]   coef_sel_c;
  logic signed [PROD_W-1:0]       prod_c;
  logic signed [DATA_WIDTH-1:0]   result_c;

  // Shared multiplier, operands selected by the tap counter.
  always_comb begin
    x_sel_c    = delay[tap];
    coef_sel_c = COEFS[tap*COEF_WIDTH +: COEF_WIDTH];
    prod_c     = PROD_W'(x_sel_c) * PROD_W'(coef_sel_c);
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (sample_valid_i) state_next = MAC;
      MAC:     if (tap == LAST_TAP) state_next = OUT;
      OUT:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Delay line, accumulator and output registers; samples outside IDLE are dropped.
  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      for (int i = 0; i < NUM_TAPS; i++) delay[i] <= '0;
      tap          <= '0;
      acc          <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
    end else begin
      data_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid_i) begin
            delay[0] <= data_i;
            for (int i = 1; i < NUM_TAPS; i++) delay[i] <= delay[i-1];
            acc <= '0;
            tap <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_WIDTH'(prod_c);
          tap <= tap + CNT_W'(1);
        end
        OUT: begin
          data_o       <= result_c;
          data_valid_o <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  dsp_fir_round_sat #(
    .ACC_WIDTH  (ACC_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_FRAC  (COEF_FRAC)
  ) u_round_sat (
    .acc      (acc),
    .result_c (result_c)
  );

endmodule

// File: tb/tb_dsp_fir_core.sv
// Directed table-driven bench for dsp_fir_core: default moving average plus a high-gain
// instance that exercises output saturation.
module tb_dsp_fir_core;
  import dsp_fir_pkg::*;

  localparam logic [TAPS*COEF_W-1:0] SAT_COEFS = {TAPS{COEF_W'(32767)}};
  localparam int LATENCY = TAPS + 1;

  logic    clk = 1'b0;
  logic    srst;
  logic    valid;
  sample_t data;
  sample_t y_main;
  sample_t y_sat;
  logic    dv_main;
  logic    dv_sat;

  always #5 clk = ~clk;

  dsp_fir_core dut (
    .clk_i          (clk),
    .srst_i         (srst),
    .sample_valid_i (valid),
    .data_i         (data),
    .data_o         (y_main),
    .data_valid_o   (dv_main)
  );

  dsp_fir_core #(.COEFS(SAT_COEFS)) dut_sat (
    .clk_i          (clk),
    .srst_i         (srst),
    .sample_valid_i (valid),
    .data_i         (data),
    .data_o         (y_sat),
    .data_valid_o   (dv_sat)
  );

  typedef struct {
    bit rst;
    int x;
    int y;
    int ys;
    bit cs;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic void add(input bit r, input int x, input int y, input int ys, input bit cs);
    vec_t v;
    v.rst = r; v.x = x; v.y = y; v.ys = ys; v.cs = cs;
    vecs.push_back(v);
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    srst  = 1'b1;
    valid = 1'b0;
    repeat (2) @(negedge clk);
    srst = 1'b0;
  endtask

  // One sample pulse, then wait (bounded) for the result pulse.
  task automatic send(input int x, output int y, output int ys, output int lat, output int svld);
    @(negedge clk);
    valid = 1'b1;
    data  = sample_t'(x);
    @(negedge clk);
    valid = 1'b0;
    data  = sample_t'($urandom);
    lat = -1; y = 0; ys = 0; svld = 0;
    for (int n = 0; n < 40; n++) begin
      if (n > 0) begin
        @(negedge clk);
        data = sample_t'($urandom);
      end
      if (dv_main) begin
        lat = n; y = y_main; ys = y_sat; svld = int'(dv_sat);
        break;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int y, ys, lat, svld, pulses, yv, kk, e;

    srst  = 1'b1;
    valid = 1'b0;
    data  = '0;
    repeat (2) @(negedge clk);
    check("reset_data_o", int'(y_main), 0);
    check("reset_valid", int'(dv_main), 0);
    srst = 1'b0;

    // Impulse, step, full-scale (both signs) and rounding vectors.
    add(1'b0, 16384, 1024, 0, 1'b0);
    for (int k = 0; k < 15; k++) add(1'b0, 0, 1024, 0, 1'b0);
    add(1'b0, 0, 0, 0, 1'b0);
    for (int k = 1; k <= 18; k++) add(1'b0, 1600, (k <= 16) ? 100 * k : 1600, 0, 1'b0);
    for (int k = 1; k <= 17; k++) begin
      kk = (k > 16) ? 16 : k;
`ifdef DSP_FIR_ROUND_EN
      e = (kk <= 8) ? 2048 * kk : 2048 * kk - 1;
`else
      e = 2048 * kk - 1;
`endif
      add(k == 1, 32767, e, (kk == 1) ? 32766 : 32767, 1'b1);
    end
    for (int k = 1; k <= 17; k++) begin
      kk = (k > 16) ? 16 : k;
      add(k == 1, -32768, -2048 * kk, (kk == 1) ? -32767 : -32768, 1'b1);
    end
    add(1'b1, 1, 0, 0, 1'b0);
`ifdef DSP_FIR_ROUND_EN
    add(1'b1, 8, 1, 0, 1'b0);
`else
    add(1'b1, 8, 0, 0, 1'b0);
`endif

    foreach (vecs[i]) begin
      if (vecs[i].rst) apply_reset();
      send(vecs[i].x, y, ys, lat, svld);
      check($sformatf("vec%0d_latency", i), lat, LATENCY);
      check($sformatf("vec%0d_data", i), y, vecs[i].y);
      if (vecs[i].cs) begin
        check($sformatf("vec%0d_sat_valid", i), svld, 1);
        check($sformatf("vec%0d_sat_data", i), ys, vecs[i].ys);
      end
      @(negedge clk);
      check($sformatf("vec%0d_pulse_width", i), int'(dv_main), 0);
      check($sformatf("vec%0d_hold", i), int'(y_main), vecs[i].y);
    end

    // Re-pulse while busy must be dropped.
    apply_reset();
    @(negedge clk);
    valid = 1'b1;
    data  = sample_t'(16384);
    pulses = 0; lat = -1; yv = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      valid = (n == 4);
      data  = (n == 4) ? sample_t'(999) : sample_t'($urandom);
      if (dv_main) begin
        pulses++; lat = n; yv = int'(y_main);
      end
    end
    valid = 1'b0;
    check("repulse_count", pulses, 1);
    check("repulse_latency", lat, LATENCY);
    check("repulse_data", yv, 1024);
    send(0, y, ys, lat, svld);
    check("repulse_next_data", y, 1024);

    // Reset in the middle of MAC aborts the sample.
    @(negedge clk);
    valid = 1'b1;
    data  = sample_t'(16384);
    @(negedge clk);
    valid = 1'b0;
    repeat (5) @(negedge clk);
    srst = 1'b1;
    #1;
    check("midmac_rst_data", int'(y_main), 0);
    check("midmac_rst_valid", int'(dv_main), 0);
    repeat (2) @(negedge clk);
    srst = 1'b0;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (dv_main) pulses++;
    end
    check("midmac_no_pulse", pulses, 0);
    send(16384, y, ys, lat, svld);
    check("after_rst_latency", lat, LATENCY);
    check("after_rst_data", y, 1024);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
